// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding SRAM fetch,
// buffers one response while decode stalls, and squashes wrong-path fetches.
//   state | meaning
//   IDLE  | first cycle out of reset
//   REQ   | request driven, waiting for accept
//   WAIT  | request accepted, waiting for response
//   HOLD  | response parked, output register full and stalled
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c00_0000,
  parameter logic [31:0] NOP_INST = 32'h0340_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        inst_req_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_ready_i,
  input  logic        inst_rvalid_i,
  input  logic [31:0] inst_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_target, w_target_nxt;
  logic        r_kill, w_kill_nxt;
  logic [31:0] r_hold_pc, w_hold_pc_nxt;
  logic [31:0] r_hold_inst, w_hold_inst_nxt;
  logic [31:0] r_out_pc, w_out_pc_nxt;
  logic [31:0] r_out_inst, w_out_inst_nxt;
  logic        r_out_valid, w_out_valid_nxt;
  logic        w_can_load;
  logic [31:0] w_br_pc;
  logic        w_unused_tgt_lsb;

  assign w_br_pc          = {branch_target_i[31:2], 2'b00};
  assign w_unused_tgt_lsb = ^branch_target_i[1:0];
  assign w_can_load       = !r_out_valid || !stall_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_target    <= RESET_PC;
      r_kill      <= 1'b0;
      r_hold_pc   <= 32'h0;
      r_hold_inst <= NOP_INST;
      r_out_pc    <= 32'h0;
      r_out_inst  <= NOP_INST;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_target    <= w_target_nxt;
      r_kill      <= w_kill_nxt;
      r_hold_pc   <= w_hold_pc_nxt;
      r_hold_inst <= w_hold_inst_nxt;
      r_out_pc    <= w_out_pc_nxt;
      r_out_inst  <= w_out_inst_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_target_nxt    = r_target;
    w_kill_nxt      = r_kill;
    w_hold_pc_nxt   = r_hold_pc;
    w_hold_inst_nxt = r_hold_inst;
    w_out_pc_nxt    = r_out_pc;
    w_out_inst_nxt  = r_out_inst;
    w_out_valid_nxt = r_out_valid;

    if (r_out_valid && !stall_i) begin
      w_out_valid_nxt = 1'b0;
      w_out_inst_nxt  = NOP_INST;
    end

    if (branch_flag_i) begin
      w_out_valid_nxt = 1'b0;
      w_out_inst_nxt  = NOP_INST;
      case (r_state)
        S_REQ: begin
          // address must stay stable until accepted; the answer is dropped later
          w_kill_nxt   = 1'b1;
          w_target_nxt = w_br_pc;
          if (inst_ready_i) w_state_nxt = S_WAIT;
        end
        S_WAIT: begin
          if (inst_rvalid_i) begin
            w_pc_nxt    = w_br_pc;
            w_kill_nxt  = 1'b0;
            w_state_nxt = S_REQ;
          end else begin
            w_kill_nxt   = 1'b1;
            w_target_nxt = w_br_pc;
          end
        end
        default: begin
          w_pc_nxt    = w_br_pc;
          w_kill_nxt  = 1'b0;
          w_state_nxt = S_REQ;
        end
      endcase
    end else begin
      case (r_state)
        S_IDLE: w_state_nxt = S_REQ;
        S_REQ: begin
          if (inst_ready_i) w_state_nxt = S_WAIT;
        end
        S_WAIT: begin
          if (inst_rvalid_i) begin
            if (r_kill) begin
              w_pc_nxt    = r_target;
              w_kill_nxt  = 1'b0;
              w_state_nxt = S_REQ;
            end else if (w_can_load) begin
              w_out_pc_nxt    = r_pc;
              w_out_inst_nxt  = inst_rdata_i;
              w_out_valid_nxt = 1'b1;
              w_pc_nxt        = r_pc + 32'd4;
              w_state_nxt     = S_REQ;
            end else begin
              w_hold_pc_nxt   = r_pc;
              w_hold_inst_nxt = inst_rdata_i;
              w_pc_nxt        = r_pc + 32'd4;
              w_state_nxt     = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (w_can_load) begin
            w_out_pc_nxt    = r_hold_pc;
            w_out_inst_nxt  = r_hold_inst;
            w_out_valid_nxt = 1'b1;
            w_state_nxt     = S_REQ;
          end
        end
      endcase
    end
  end

  assign inst_req_o   = (r_state == S_REQ);
  assign inst_addr_o  = r_pc;
  assign pc_o         = r_out_pc;
  assign inst_o       = r_out_inst;
  assign inst_valid_o = r_out_valid;

endmodule
